// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default frame format.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_PARITY_EN  = 0;
  localparam int DEF_PARITY_ODD = 0;
  localparam int DEF_STOP_BITS  = 1;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS LSB first, optional parity, 1-2 stop bits,
// paced by an external one-clock baud tick; o_tx is registered so it only moves on a tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int PARITY_EN  = DEF_PARITY_EN,
  parameter int PARITY_ODD = DEF_PARITY_ODD,
  parameter int STOP_BITS  = DEF_STOP_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_baud_tick,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int            CW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  uart_state_t          state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [CW-1:0]        bit_cnt, bit_cnt_nxt;
  logic                 stop_cnt, stop_cnt_nxt;
  logic                 tx_q, tx_nxt;
  logic                 done_q, done_nxt;
  logic                 par_bit;
  logic                 last_stop;

  assign par_bit   = (^shreg) ^ (PARITY_ODD != 0);
  assign last_stop = (STOP_BITS < 2) ? 1'b1 : stop_cnt;

  // The byte stays put for the whole frame; the bit counter selects what goes out.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    tx_nxt       = tx_q;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (i_valid) begin
          shreg_nxt    = i_data;
          bit_cnt_nxt  = '0;
          stop_cnt_nxt = 1'b0;
          state_nxt    = ARMED;
        end
      end
      ARMED: begin
        if (i_baud_tick) begin
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (i_baud_tick) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
          tx_nxt      = shreg[0];
        end
      end
      DATA: begin
        if (i_baud_tick) begin
          if (bit_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_nxt = PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt    = STOP;
              stop_cnt_nxt = 1'b0;
              tx_nxt       = 1'b1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            tx_nxt      = shreg[bit_cnt_nxt];
          end
        end
      end
      PARITY: begin
        if (i_baud_tick) begin
          state_nxt    = STOP;
          stop_cnt_nxt = 1'b0;
          tx_nxt       = 1'b1;
        end
      end
      STOP: begin
        if (i_baud_tick) begin
          if (last_stop) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      tx_q     <= tx_nxt;
      done_q   <= done_nxt;
    end
  end

  assign o_ready = (state == IDLE);
  assign o_busy  = ~o_ready;
  assign o_tx    = tx_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four frame formats (8N1, 8E1, 8O1, 8N2) driven in parallel and
// compared cycle by cycle against a tick-counting frame model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       valid;
  logic [7:0] data;
  logic [3:0] tx, rdy, bsy, dn;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) d0 (
    .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_data(data), .i_valid(valid),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(bsy[0]), .o_done(dn[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) d1 (
    .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_data(data), .i_valid(valid),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(bsy[1]), .o_done(dn[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) d2 (
    .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_data(data), .i_valid(valid),
    .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(bsy[2]), .o_done(dn[2]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) d3 (
    .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_data(data), .i_valid(valid),
    .o_ready(rdy[3]), .o_tx(tx[3]), .o_busy(bsy[3]), .o_done(dn[3]));

  localparam int PEN  [4] = '{0, 1, 1, 0};
  localparam int PODD [4] = '{0, 0, 1, 0};
  localparam int SB   [4] = '{1, 1, 1, 2};

  // Model: a frame is a list of line levels; tick k after acceptance starts level k-1.
  bit m_busy  [4];
  int m_ticks [4];
  bit m_done  [4];
  int m_len   [4];
  int m_acc   [4];
  bit m_frame [4][12];

  int n_cmp = 0;
  int n_bad = 0;

  logic cap [4][32];
  int   cap_n [4];
  int   done_cnt [4];
  int   low_cnt;
  int   cyc = 0;
  bit   prev_rdy0 = 1'b1;
  int   fall0 [4];
  int   nf;
  int   first_done0;

  typedef struct {
    logic [7:0] dat;
    int         period;
    int         phase;
    logic [9:0] f81;
    logic       pe;
    logic       po;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic build_frame(input int d, input logic [7:0] dat);
    int n;
    m_frame[d][0] = 1'b0;
    for (int j = 0; j < 8; j++) m_frame[d][1+j] = dat[j];
    n = 9;
    if (PEN[d] != 0) begin
      m_frame[d][n] = (^dat) ^ PODD[d][0];
      n++;
    end
    for (int s = 0; s < SB[d]; s++) begin
      m_frame[d][n] = 1'b1;
      n++;
    end
    m_len[d] = n;
  endtask

  function automatic logic exp_tx(input int d);
    if (!m_busy[d] || m_ticks[d] == 0) return 1'b1;
    return m_frame[d][m_ticks[d]-1];
  endfunction

  function automatic bit all_idle();
    return !m_busy[0] && !m_busy[1] && !m_busy[2] && !m_busy[3];
  endfunction

  function automatic bit all_busy();
    return m_busy[0] && m_busy[1] && m_busy[2] && m_busy[3];
  endfunction

  // Called at a falling edge: check outputs, drive this cycle's inputs, advance model.
  task automatic step(input bit v, input bit t);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("cycle d%0d {tx,rdy,busy,done}", d), {28'd0, tx[d], rdy[d], bsy[d], dn[d]},
            {28'd0, exp_tx(d), !m_busy[d], m_busy[d], m_done[d]});
      if (t && m_busy[d] && cap_n[d] < 32) begin
        cap[d][cap_n[d]] = tx[d];
        cap_n[d]++;
      end
      if (dn[d]) done_cnt[d]++;
    end
    if (!tx[0]) low_cnt++;
    if (dn[0] && first_done0 < 0) first_done0 = cyc;
    if (prev_rdy0 && !rdy[0] && nf < 4) begin
      fall0[nf] = cyc;
      nf++;
    end
    prev_rdy0 = rdy[0];
    valid = v;
    tick  = t;
    for (int d = 0; d < 4; d++) begin
      m_done[d] = 1'b0;
      if (rst) begin
        m_busy[d] = 1'b0;
      end else if (!m_busy[d]) begin
        if (v) begin
          m_busy[d]  = 1'b1;
          m_ticks[d] = 0;
          m_acc[d]++;
          build_frame(d, data);
        end
      end else if (t) begin
        m_ticks[d]++;
        if (m_ticks[d] == m_len[d] + 1) begin
          m_busy[d] = 1'b0;
          m_done[d] = 1'b1;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_obs();
    for (int d = 0; d < 4; d++) begin
      cap_n[d]    = 0;
      done_cnt[d] = 0;
    end
    low_cnt     = 0;
    nf          = 0;
    first_done0 = -1;
  endtask

  // period 0 selects irregular random ticks and random ignored i_valid mid-frame.
  task automatic run_frame(input logic [7:0] dat, input int period, input int phase);
    int  limit;
    bit  v, t;
    clear_obs();
    data  = dat;
    limit = (period > 0) ? 16 * period + 8 : 400;
    for (int i = 0; i < limit; i++) begin
      t = (period > 0) ? ((i + phase) % period == 0) : ($urandom_range(0, 3) == 0);
      v = (i == 0);
      if (period == 0 && i > 0 && all_busy() && $urandom_range(0, 7) == 0) begin
        v    = 1'b1;
        data = 8'($urandom);
      end
      step(v, t);
      if (i > 0 && all_idle()) break;
    end
    step(1'b0, 1'b0);
    check("frame end ready", {28'd0, rdy}, 32'hF);
  endtask

  initial begin
    logic [9:0] got;
    int         acc0 [4];
    bit         v;
    bit         pre_bit;

    tbl[0] = '{8'hA5, 16, 5, 10'b1101001010, 1'b0, 1'b1};
    tbl[1] = '{8'h07, 16, 3, 10'b1000001110, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 16, 0, 10'b1111111110, 1'b0, 1'b1};
    tbl[3] = '{8'h00,  4, 1, 10'b1000000000, 1'b0, 1'b1};
    tbl[4] = '{8'h3C,  7, 2, 10'b1001111000, 1'b0, 1'b1};

    rst   = 1'b1;
    valid = 1'b0;
    tick  = 1'b0;
    data  = 8'h00;
    clear_obs();
    @(negedge clk);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

    // Directed frames (ticks coinciding with acceptance when phase is 0).
    for (int k = 0; k < 5; k++) begin
      run_frame(tbl[k].dat, tbl[k].period, tbl[k].phase);
      for (int d = 0; d < 4; d++) begin
        check($sformatf("v%0d tick samples d%0d", k, d), cap_n[d], m_len[d] + 1);
        check($sformatf("v%0d done count d%0d", k, d), done_cnt[d], 1);
      end
      for (int j = 0; j < 10; j++) got[j] = cap[0][j+1];
      check($sformatf("v%0d 8N1 line bits", k), {22'd0, got}, {22'd0, tbl[k].f81});
      check($sformatf("v%0d even parity", k), {31'd0, cap[1][10]}, {31'd0, tbl[k].pe});
      check($sformatf("v%0d odd parity", k), {31'd0, cap[2][10]}, {31'd0, tbl[k].po});
      check($sformatf("v%0d two stop bits", k), {30'd0, cap[3][10], cap[3][11]}, 32'd3);
      check($sformatf("v%0d start+zero low clocks", k), low_cnt,
            tbl[k].period * (1 + 8 - $countones(tbl[k].dat)));
    end

    // Back-to-back with i_valid held high: 0x11 then 0x22.
    clear_obs();
    data = 8'h11;
    for (int d = 0; d < 4; d++) acc0[d] = m_acc[d];
    for (int i = 0; i < 300; i++) begin
      v = 1'b0;
      for (int d = 0; d < 4; d++) if (m_acc[d] < acc0[d] + 2) v = 1'b1;
      step(v, (i % 4) == 1);
      if (i == 0) data = 8'h22;
      if (!v && all_idle()) break;
    end
    step(1'b0, 1'b0);
    for (int d = 0; d < 4; d++) check($sformatf("b2b done count d%0d", d), done_cnt[d], 2);
    check("b2b accept count d0", nf, 2);
    check("b2b second accept after done", fall0[1], first_done0 + 1);
    for (int j = 0; j < 10; j++) got[j] = cap[0][j+1];
    check("b2b frame1 bits", {22'd0, got}, 32'b1000100010);
    for (int j = 0; j < 10; j++) got[j] = cap[0][j+12];
    check("b2b frame2 bits", {22'd0, got}, 32'b1001000100);

    // Reset during data bit 3, then a clean frame straight after release.
    clear_obs();
    data = 8'h52;
    for (int i = 0; i < 100; i++) begin
      step(i == 0, (i % 8) == 1);
      if (m_busy[0] && m_ticks[0] == 5) break;
    end
    pre_bit = data[3];
    check("line before reset", {31'd0, tx[0]}, {31'd0, pre_bit});
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 4; d++)
      check($sformatf("async reset d%0d {tx,rdy,busy,done}", d), {28'd0, tx[d], rdy[d], bsy[d], dn[d]}, 32'hC);
    for (int d = 0; d < 4; d++) begin
      m_busy[d] = 1'b0;
      m_done[d] = 1'b0;
    end
    @(negedge clk);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("no done on abort", done_cnt[0], 0);
    rst = 1'b0;
    run_frame(8'h52, 8, 3);
    check("post-reset done count", done_cnt[0], 1);
    for (int j = 0; j < 10; j++) got[j] = cap[0][j+1];
    check("post-reset frame bits", {22'd0, got}, 32'b1010100100);

    // Random data, irregular ticks, ignored mid-frame i_valid, ticks while idle.
    for (int k = 0; k < 25; k++) begin
      run_frame(8'($urandom), 0, 0);
      for (int d = 0; d < 4; d++) check($sformatf("rnd%0d done d%0d", k, d), done_cnt[d], 1);
      for (int i = 0; i < $urandom_range(0, 4); i++) step(1'b0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter PARITY_EN, default 0, where 1 inserts a parity bit after the data bits.
REQ-003 SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-004 SHALL have parameter STOP_BITS, default 1, number of stop bits (1 or 2).
REQ-005 SHALL have port i_clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port i_baud_tick, input, 1 bit: one-clock strobe per bit period, supplied by the baud generator.
REQ-008 SHALL have port i_data, input, DATA_BITS bits: byte to transmit.
REQ-009 SHALL have port i_valid, input, 1 bit: i_data is valid.
REQ-010 SHALL have port o_ready, output, 1 bit: the block can accept a byte.
REQ-011 SHALL have port o_tx, output, 1 bit: serial line, idle high.
REQ-012 SHALL have port o_busy, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port o_done, output, 1 bit: one-clock pulse when a frame completes.

Function
REQ-014 SHALL implement states IDLE, ARMED, START, DATA, PARITY, STOP.
REQ-015 SHALL drive o_ready high if and only if state is IDLE; o_busy SHALL equal the inverse of o_ready.
REQ-016 SHALL accept a byte on a clock where i_valid and o_ready are both high: latch i_data into the shift register and move to ARMED.
REQ-017 SHALL hold o_tx high in IDLE and ARMED; ARMED SHALL wait for the next i_baud_tick, then move to START.
REQ-018 SHALL NOT count an i_baud_tick that falls in the acceptance cycle; the start bit begins on the first tick after acceptance.
REQ-019 SHALL drive o_tx low in START; the next tick moves to DATA with the bit counter at 0.
REQ-020 SHALL transmit data bits LSB first in DATA, one bit per tick; on the tick ending bit DATA_BITS-1, SHALL move to PARITY if PARITY_EN=1, else to STOP.
REQ-021 SHALL drive parity in PARITY as the XOR of the latched data bits, inverted when PARITY_ODD=1, for one tick period.
REQ-022 SHALL drive o_tx high in STOP for STOP_BITS tick periods.
REQ-023 SHALL, on the tick ending the last stop bit, return to IDLE and pulse o_done high for exactly that one clock.
REQ-024 SHALL support back-to-back frames: a byte presented with i_valid on the first IDLE clock is accepted, leaving no gap beyond the ARMED wait.
REQ-025 SHALL ignore i_valid and i_data while not in IDLE; the latched byte SHALL NOT change mid-frame.
REQ-026 SHALL size the bit counter as clog2(DATA_BITS) bits and the stop counter as 1 bit; neither counter SHALL wrap outside its state.
REQ-027 SHALL keep o_tx registered and glitch-free; it SHALL change only on clocks where i_baud_tick is high, or on the clock after acceptance.
REQ-028 SHALL ignore i_baud_tick in IDLE.

Reset
REQ-029 SHALL, on assertion of i_rst, immediately force state to IDLE, o_tx=1, o_ready=1, o_busy=0, o_done=0, and clear all counters and the shift register.
REQ-030 SHALL abort a frame when reset asserts mid-frame, with the line returning high at once and no o_done pulse.
REQ-031 SHALL allow the first acceptance on the first clock edge after i_rst deasserts.

Structure
REQ-032 SHALL place the state enumeration and the default parameter constants in shared package uart_pkg, for reuse by the future uart_rx.
REQ-033 SHALL need no sub-module; the baud generator SHALL be instantiated alongside uart_tx at the top level, not inside it.

Verification
REQ-034 SHALL cover 8N1, tick every 16 clocks, i_data=0xA5: o_tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit 16 clocks, and o_done once.
REQ-035 SHALL cover PARITY_EN=1 with PARITY_ODD=0, i_data=0x07: parity bit 1; with PARITY_ODD=1, parity bit 0.
REQ-036 SHALL cover STOP_BITS=2, i_data=0xFF: o_tx high for 2 tick periods after the last data bit before o_done.
REQ-037 SHALL cover i_valid held high with bytes 0x11 then 0x22: second acceptance on the clock after o_done, and two complete frames.
REQ-038 SHALL cover i_rst asserted during data bit 3: o_tx=1 and o_ready=1 in the same cycle, no o_done, and a clean new frame afterwards.
REQ-039 SHALL cover i_baud_tick coinciding with acceptance: start bit begins on the following tick and lasts a full bit period.
